// File: rtl/neuron_mac.sv
// Serial 4-term signed dot product with fixed-point rescale and 8-bit saturation.
// Optional build macro NEURON_MAC_RELU_EN clamps negative results to zero.
module neuron_mac #(
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 2*DATA_W+2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] w0,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] w2,
    input  logic signed [DATA_W-1:0] w3,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] result
);

    // state | meaning
    // IDLE  | waiting for start, operands free to change
    // MAC   | accumulating term idx (0..3), one per cycle
    // DONE  | result valid, done pulse high for this single cycle
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_W-1))-1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

    state_t state, state_nxt;

    logic signed [DATA_W-1:0]   w_q [4];
    logic signed [DATA_W-1:0]   x_q [4];
    logic        [1:0]          idx;
    logic signed [ACC_W-1:0]    acc;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   sat_val;
    logic signed [DATA_W-1:0]   out_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prod     = w_q[idx] * x_q[idx];
        prod_ext = ACC_W'(prod);
        sum      = acc + prod_ext;
        shifted  = sum >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
`ifdef NEURON_MAC_RELU_EN
        out_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        out_val = sat_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_q[0] <= w0;
                        w_q[1] <= w1;
                        w_q[2] <= w2;
                        w_q[3] <= w3;
                        x_q[0] <= x0;
                        x_q[1] <= x1;
                        x_q[2] <= x2;
                        x_q[3] <= x3;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                MAC: begin
                    acc <= sum;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        result <= out_val;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_neuron_mac.sv
// Directed-vector bench for neuron_mac; expectations follow the build's NEURON_MAC_RELU_EN setting.
module tb_neuron_mac;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic signed [7:0] w0, w1, w2, w3;
    logic signed [7:0] x0, x1, x2, x3;
    logic              busy;
    logic              done;
    logic signed [7:0] result;

    int n_vec = 0;
    int n_err = 0;

    neuron_mac dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .w0     (w0),
        .w1     (w1),
        .w2     (w2),
        .w3     (w3),
        .x0     (x0),
        .x1     (x1),
        .x2     (x2),
        .x3     (x3),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        w0 = 8'(a0); w1 = 8'(a1); w2 = 8'(a2); w3 = 8'(a3);
        x0 = 8'(b0); x1 = 8'(b1); x2 = 8'(b2); x3 = 8'(b3);
    endtask

    // One-cycle start, then check busy/done across the full 5-cycle window and the return to idle.
    task automatic run_mac(input string tag,
                           input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input int exp);
        set_ops(a0, a1, a2, a3, b0, b1, b2, b3);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_busy"}, int'(busy), 1);
            check({tag, "_done"}, int'(done), (i == 4) ? 1 : 0);
            if (i < 4) tick();
        end
        check({tag, "_result"}, int'(result), exp);
        tick();
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_done"}, int'(done), 0);
        check({tag, "_hold"}, int'(result), exp);
    endtask

    int exp_neg;
    int exp_m1;
    int exp_m2048;
    int done_cnt;
    int cap;

    initial begin
`ifdef NEURON_MAC_RELU_EN
        exp_neg   = 0;
        exp_m1    = 0;
        exp_m2048 = 0;
`else
        exp_neg   = -128;
        exp_m1    = -1;
        exp_m2048 = -128;
`endif
        reset = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_result", int'(result), 0);
            check("rst_done", int'(done), 0);
            check("rst_busy", int'(busy), 0);
        end

        run_mac("basic",   16, 16, 16, 16,   16, 32, -16, 8,    40);
        run_mac("possat", 127, 127, 127, 127, 127, 127, 127, 127, 127);
        run_mac("negsat", 127, 127, 127, 127, -128, -128, -128, -128, exp_neg);
        run_mac("mixed",    1, 2, 3, 4,       5, 6, 7, 8,        4);
        run_mac("trunc",    1, 0, 0, 0,      -1, 0, 0, 0,        exp_m1);
        run_mac("edge127", 127, 0, 0, 0,     16, 0, 0, 0,       127);
        run_mac("edge128",  16, 16, 0, 0,    64, 64, 0, 0,      127);
        run_mac("edgem129", -128, 1, 0, 0,   16, -16, 0, 0,     exp_m2048);
        tick();

        // Operand isolation and start while busy.
        set_ops(16, 16, 16, 16, 16, 16, 16, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_ops(0, 0, 0, 0, 16, 16, 16, 16);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        cap = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                done_cnt++;
                cap = int'(result);
            end
            tick();
        end
        check("iso_done_cnt", done_cnt, 1);
        check("iso_result", cap, 64);
        check("iso_idle", int'(busy), 0);

        // Reset during the second MAC cycle.
        set_ops(16, 16, 16, 16, 16, 32, -16, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_result", int'(result), 0);
        tick();
        run_mac("after_rst", 16, 16, 16, 16, 16, 32, -16, 8, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
